// File: rtl/pll_reset_seq_pkg.sv
// Purpose : shared types and constants for the PLL reset sequencer.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
package pll_reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    MEM       = 3'd2,
    PERIPH    = 3'd3,
    RUN       = 3'd4
  } seq_state_t;

  localparam logic [7:0] LOSS_MAX = 8'd255;

  // Width of a counter that must reach (largest terminal count - 1).
  function automatic int cnt_width(input int lock_stable, input int stage_delay,
                                   input int debounce);
    int m;
    m = lock_stable;
    if (stage_delay > m) m = stage_delay;
    if (debounce > m) m = debounce;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_reset_seq_sync2.sv
// Purpose : two-flop synchroniser bringing an asynchronous level into 'clock'.
// Latency : 2 clock edges from d to q.
// Backpressure : none; free-running level path.
// Ports   : clock, reset (async active-high, clears both flops), d (async in), q (synchronised out).
module pll_reset_seq_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Purpose : waits for stable PLL lock, then releases memory, video+GPU, CPU resets in order.
// Latency : rst_memory falls LOCK_STABLE+2 edges after locked is first sampled high; each later stage STAGE_DELAY edges on.
// Backpressure : none; any lock loss (or debounced button press) re-asserts every reset on the next edge.
// Ports   : clock, reset (async active-high), locked (async PLL flag),
//           rst_memory/rst_video/rst_gpu/rst_cpu (active-high resets), ready (RUN),
//           lock_loss_count (saturating, 8 bit).
// Macro   : RESET_BUTTON_EN adds input 'btn' (async, active-high) with a DEBOUNCE-cycle filter.
module pll_reset_sequencer
  import pll_reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE = 1024,
  parameter int STAGE_DELAY = 256,
  parameter int DEBOUNCE    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
`ifdef RESET_BUTTON_EN
  input  logic       btn,
`endif
  output logic       rst_memory,
  output logic       rst_video,
  output logic       rst_gpu,
  output logic       rst_cpu,
  output logic       ready,
  output logic [7:0] lock_loss_count
);

  localparam int CW = cnt_width(LOCK_STABLE, STAGE_DELAY, DEBOUNCE);

  logic locked_sync;
  logic btn_hold;  // debounced button level; holds the sequencer in WAIT_LOCK

  pll_reset_seq_sync2 u_sync_locked (
    .clock (clock),
    .reset (reset),
    .d     (locked),
    .q     (locked_sync)
  );

`ifdef RESET_BUTTON_EN
  logic          btn_sync;
  logic          btn_deb_q, btn_deb_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;

  pll_reset_seq_sync2 u_sync_btn (
    .clock (clock),
    .reset (reset),
    .d     (btn),
    .q     (btn_sync)
  );

  // The level only flips after btn_sync has disagreed with it for DEBOUNCE
  // consecutive cycles; any agreeing cycle restarts the count.
  always_comb begin
    btn_deb_d = btn_deb_q;
    deb_cnt_d = '0;
    if (btn_sync != btn_deb_q) begin
      if (deb_cnt_q == CW'(DEBOUNCE - 1)) begin
        btn_deb_d = btn_sync;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_deb_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      btn_deb_q <= btn_deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign btn_hold = btn_deb_q;
`else
  assign btn_hold = 1'b0;
`endif

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    loss_q, loss_d;
  logic          rst_memory_q, rst_memory_d;
  logic          rst_video_q, rst_video_d;
  logic          rst_gpu_q, rst_gpu_d;
  logic          rst_cpu_q, rst_cpu_d;
  logic          ready_q, ready_d;
  logic          lock_lost;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    loss_d    = loss_q;
    lock_lost = (state_q != WAIT_LOCK) && !locked_sync;

    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_sync && !btn_hold) state_d = STABLE;
      end
      STABLE: begin
        if (cnt_q == CW'(LOCK_STABLE - 1)) begin
          state_d = MEM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEM: begin
        if (cnt_q == CW'(STAGE_DELAY - 1)) begin
          state_d = PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PERIPH: begin
        if (cnt_q == CW'(STAGE_DELAY - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides any terminal count reached in the same cycle.
    if ((state_q != WAIT_LOCK) && (lock_lost || btn_hold)) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end
    // Only a real lock loss is counted, once even if the button also fired.
    if (lock_lost && (loss_q != LOSS_MAX)) loss_d = loss_q + 8'd1;

    // Outputs are registered from the next state so they change on the same
    // edge as the state register.
    rst_memory_d = !((state_d == MEM) || (state_d == PERIPH) || (state_d == RUN));
    rst_video_d  = !((state_d == PERIPH) || (state_d == RUN));
    rst_gpu_d    = !((state_d == PERIPH) || (state_d == RUN));
    rst_cpu_d    = (state_d != RUN);
    ready_d      = (state_d == RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      loss_q       <= 8'd0;
      rst_memory_q <= 1'b1;
      rst_video_q  <= 1'b1;
      rst_gpu_q    <= 1'b1;
      rst_cpu_q    <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      loss_q       <= loss_d;
      rst_memory_q <= rst_memory_d;
      rst_video_q  <= rst_video_d;
      rst_gpu_q    <= rst_gpu_d;
      rst_cpu_q    <= rst_cpu_d;
      ready_q      <= ready_d;
    end
  end

  assign rst_memory      = rst_memory_q;
  assign rst_video       = rst_video_q;
  assign rst_gpu         = rst_gpu_q;
  assign rst_cpu         = rst_cpu_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose : directed self-checking bench for pll_reset_sequencer (LOCK_STABLE=16, STAGE_DELAY=8, DEBOUNCE=4).
// Latency : outputs sampled 1 time unit after each rising clock edge.
// Backpressure : n/a.
module tb_pll_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b0;
`ifdef RESET_BUTTON_EN
  logic       btn = 1'b0;
`endif
  logic       rst_memory, rst_video, rst_gpu, rst_cpu, ready;
  logic [7:0] lock_loss_count;
  logic [4:0] obs;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign obs = {rst_memory, rst_video, rst_gpu, rst_cpu, ready};

  pll_reset_sequencer #(
    .LOCK_STABLE (16),
    .STAGE_DELAY (8),
    .DEBOUNCE    (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .locked          (locked),
`ifdef RESET_BUTTON_EN
    .btn             (btn),
`endif
    .rst_memory      (rst_memory),
    .rst_video       (rst_video),
    .rst_gpu         (rst_gpu),
    .rst_cpu         (rst_cpu),
    .ready           (ready),
    .lock_loss_count (lock_loss_count)
  );

  // Expected {rst_memory, rst_video, rst_gpu, rst_cpu, ready} at relative edge k
  // when rst_memory is due to fall at edge mem_edge (stages 8 edges apart).
  function automatic logic [4:0] exp_vec(input int k, input int mem_edge);
    logic v;
    v = (k < mem_edge + 8);
    return {k < mem_edge, v, v, k < mem_edge + 16, k >= mem_edge + 16};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    locked = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 5'b11110) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 5'b11110);
    end
    checks++;
    if (lock_loss_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", lock_loss_count);
    end
  endtask

  // locked rises just before edge 0 and stays high.
  task automatic test_sequence();
    locked = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step();
      checks++;
      if (obs !== exp_vec(k, 18)) begin
        errors++;
        $display("FAIL seq_edge%0d: got %b expected %b", k, obs, exp_vec(k, 18));
      end
    end
    checks++;
    if (lock_loss_count !== 8'd0) begin
      errors++;
      $display("FAIL seq_count: got %0d expected 0", lock_loss_count);
    end
  endtask

  // From RUN, drop locked for 3 cycles then restore it.
  task automatic test_lock_loss();
    locked = 1'b0;
    repeat (3) step();
    checks++;
    if (obs !== 5'b11110) begin
      errors++;
      $display("FAIL loss_outputs: got %b expected %b", obs, 5'b11110);
    end
    checks++;
    if (lock_loss_count !== 8'd1) begin
      errors++;
      $display("FAIL loss_count: got %0d expected 1", lock_loss_count);
    end
    locked = 1'b1;
    for (int k = 0; k <= 35; k++) begin
      step();
      checks++;
      if (obs !== exp_vec(k, 18)) begin
        errors++;
        $display("FAIL replay_edge%0d: got %b expected %b", k, obs, exp_vec(k, 18));
      end
    end
  endtask

  // One-cycle glitch sampled at edge 13 (STABLE counter around 10);
  // the re-rise is sampled at edge 14 so memory release moves to edge 32.
  task automatic test_glitch();
    logic [7:0] exp_cnt;
    do_reset();
    for (int k = 0; k <= 33; k++) begin
      locked = (k != 13);
      step();
      exp_cnt = (k >= 15) ? 8'd1 : 8'd0;
      checks++;
      if (rst_memory !== (k < 32)) begin
        errors++;
        $display("FAIL glitch_mem_edge%0d: got %b expected %b", k, rst_memory, (k < 32));
      end
      checks++;
      if (lock_loss_count !== exp_cnt) begin
        errors++;
        $display("FAIL glitch_count_edge%0d: got %0d expected %0d", k, lock_loss_count, exp_cnt);
      end
    end
  endtask

  // Count starts at 1 from the glitch test; each iteration adds one loss.
  task automatic test_saturation();
    logic [7:0] exp_cnt;
    for (int i = 1; i <= 300; i++) begin
      locked = 1'b0;
      repeat (3) step();
      locked = 1'b1;
      repeat (3) step();
      if (i == 253 || i == 254 || i == 255 || i == 300) begin
        exp_cnt = (i >= 254) ? 8'd255 : 8'(i + 1);
        checks++;
        if (lock_loss_count !== exp_cnt) begin
          errors++;
          $display("FAIL sat_iter%0d: got %0d expected %0d", i, lock_loss_count, exp_cnt);
        end
      end
    end
  endtask

  // Async reset while in PERIPH (edges 26..33), then a clean restart.
  task automatic test_async_reset();
    do_reset();
    locked = 1'b1;
    repeat (30) step();
    checks++;
    if (obs !== exp_vec(29, 18)) begin
      errors++;
      $display("FAIL periph_reached: got %b expected %b", obs, exp_vec(29, 18));
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== 5'b11110 || lock_loss_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: got %b/%0d expected 11110/0", obs, lock_loss_count);
    end
    reset = 1'b0;
    for (int k = 0; k <= 34; k++) begin
      step();
      checks++;
      if (obs !== exp_vec(k, 18)) begin
        errors++;
        $display("FAIL restart_edge%0d: got %b expected %b", k, obs, exp_vec(k, 18));
      end
    end
  endtask

`ifdef RESET_BUTTON_EN
  // Starts in RUN with lock_loss_count = 0.
  task automatic test_button();
    btn = 1'b1;
    repeat (2) step();
    btn = 1'b0;
    repeat (8) step();
    checks++;
    if (obs !== 5'b00001) begin
      errors++;
      $display("FAIL btn_short: got %b expected %b", obs, 5'b00001);
    end
    for (int k = 0; k <= 44; k++) begin
      btn = (k < 6);
      step();
      if (k >= 6 && k <= 27) begin
        checks++;
        if (obs !== 5'b11110) begin
          errors++;
          $display("FAIL btn_hold_edge%0d: got %b expected %b", k, obs, 5'b11110);
        end
      end
      if (k >= 28) begin
        checks++;
        if (obs !== exp_vec(k, 28)) begin
          errors++;
          $display("FAIL btn_restart_edge%0d: got %b expected %b", k, obs, exp_vec(k, 28));
        end
      end
    end
    checks++;
    if (lock_loss_count !== 8'd0) begin
      errors++;
      $display("FAIL btn_count: got %0d expected 0", lock_loss_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_lock_loss();
    test_glitch();
    test_saturation();
    test_async_reset();
`ifdef RESET_BUTTON_EN
    test_button();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
